clock_field: RTL
================

# clock_field

Parametrised multi-digit BCD field register for the digital clock: one instance per time/date field (seconds, minutes, hours, day, …), replacing per-digit registers. Counts on a run-mode tick with configurable MIN/MAX wrap and one-cycle carry/borrow outputs for chaining fields. In edit mode it steps on add/sub buttons with press-and-hold auto-repeat. Also supports clear, range-checked parallel load and freeze.

## Interface
- DIGITS, 2: number of BCD digits; value width is 4*DIGITS.
- MIN_VALUE, 0: lowest legal value (decimal).
- MAX_VALUE, 59: highest legal value (decimal); MIN_VALUE < MAX_VALUE ≤ 10^DIGITS−1.
- RESET_VALUE, MIN_VALUE: value after reset; must lie in MIN..MAX.
- HOLD_CYCLES, 50_000_000: cycles a button stays held before auto-repeat starts (≥2).
- RATE_CYCLES, 10_000_000: cycles between auto-repeat steps (≥1).

- sysclk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- tick  in  1  run-mode count-up request (1-cycle pulse, e.g. carry of lower field).
- keep  in  1  freeze: ignore tick while high.
- edit  in  1  level; 1 = edit mode, 0 = run mode.
- add  in  1  level, debounced button: step up in edit mode.
- sub  in  1  level, debounced button: step down in edit mode.
- clear  in  1  force value to MIN_VALUE.
- load  in  1  1-cycle pulse: load load_value.
- load_value  in  4*DIGITS  BCD value to load.
- value  out  4*DIGITS  current field value, BCD, always in MIN..MAX.
- carry  out  1  1-cycle pulse when a tick wraps MAX→MIN.
- borrow  out  1  reserved chaining pulse; 1 only on edit-mode sub wrap MIN→MAX when edit=0 never; see Operation.
- load_err  out  1  1-cycle pulse: load rejected.

## Operation
- Priority per cycle: rst > clear > load > edit step > tick.
- rst: value=RESET_VALUE, carry=borrow=load_err=0, repeat FSM to IDLE, counter 0.
- clear: value=MIN_VALUE; no carry/borrow.
- load: accepted if every nibble ≤9 and decoded value in MIN..MAX; else value unchanged, load_err=1.
- Run mode (edit=0): tick && !keep → value+1; at MAX → MIN with carry=1. add/sub ignored; repeat FSM held in IDLE.
- Edit mode (edit=1): tick ignored and dropped (not queued); carry never asserted. Steps: up wraps MAX→MIN, down wraps MIN→MAX; wraps in edit mode do not pulse carry; borrow pulses on down-wrap (diagnostic only, not chained).
- Repeat FSM, states IDLE, HOLD, REPEAT; "press" = exactly one of add/sub high (both high or both low = released).
  - IDLE: press → step once, counter=0, go HOLD.
  - HOLD: counter increments; at HOLD_CYCLES−1 → step, counter=0, go REPEAT.
  - REPEAT: counter increments; at RATE_CYCLES−1 → step, counter=0.
  - Any state: release → IDLE, counter=0. Direction change (add↔sub in one cycle) → step in new direction, counter=0, HOLD.
  - edit falling, clear, or load → IDLE, counter=0.
- Arithmetic: internal representation free; value output valid BCD, leading digits zero.

## Timing
- All outputs registered; value reflects an event on the edge after the input is sampled (latency 1).
- carry/borrow/load_err high exactly one cycle, aligned with the value update that caused them.
- Held button: first step 1 cycle after press, second at press+HOLD_CYCLES, then every RATE_CYCLES.
- Consecutive ticks on consecutive cycles each count; tick every cycle at MAX alternates correctly.
- Reset mid-hold or mid-load: reset wins, no pulses that cycle.

## Test plan
- Bench params DIGITS=2, MIN=0, MAX=59, HOLD=4, RATE=2.
- Reset then 60 ticks → value 00..59..00, carry exactly once on 59→00; keep=1 with tick → value unchanged.
- load 0x37 → value 0x37; load 0x5A and load 0x61 → value unchanged, load_err pulse each.
- edit=1, add held 10 cycles from 0x58 → steps at cycles 1,4,6,8,10: 59,00,01,02,03; carry stays 0.
- edit=1, sub pulse at 0x00 → 0x59 with borrow pulse; tick during edit → ignored.
- clear together with load and add → value 0x00, FSM IDLE; rst during HOLD → value RESET_VALUE, next add press steps immediately.
- Second instance MIN=1, MAX=31: clear → 0x01; tick at 0x31 → 0x01 with carry.

Source files
------------

// File: rtl/clock_field.sv
// Parametrised BCD field register for the digital clock: run-mode tick counting with
// MIN/MAX wrap and carry, edit-mode add/sub stepping with press-and-hold auto-repeat.
module clock_field #(
  parameter int DIGITS      = 2,
  parameter int MIN_VALUE   = 0,
  parameter int MAX_VALUE   = 59,
  parameter int RESET_VALUE = MIN_VALUE,
  parameter int HOLD_CYCLES = 50_000_000,
  parameter int RATE_CYCLES = 10_000_000
) (
  input  logic                  sysclk,
  input  logic                  rst,
  input  logic                  tick,
  input  logic                  keep,
  input  logic                  edit,
  input  logic                  add,
  input  logic                  sub,
  input  logic                  clear,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_value,
  output logic [4*DIGITS-1:0]   value,
  output logic                  carry,
  output logic                  borrow,
  output logic                  load_err
);

  localparam int VW      = 4 * DIGITS;
  localparam int CNT_TOP = (HOLD_CYCLES > RATE_CYCLES) ? HOLD_CYCLES : RATE_CYCLES;
  localparam int CW      = $clog2(CNT_TOP + 1);

  // The first repeat fires HOLD_CYCLES after the press cycle itself, so the
  // hold counter (restarted at the press step) tops out one count earlier.
  localparam logic [CW-1:0] HOLD_LAST   = CW'(HOLD_CYCLES - 2);
  localparam logic [CW-1:0] REPEAT_LAST = CW'(RATE_CYCLES - 1);
  localparam logic [VW-1:0] MIN_BIN     = VW'(MIN_VALUE);
  localparam logic [VW-1:0] MAX_BIN     = VW'(MAX_VALUE);
  localparam logic [VW-1:0] RST_BIN     = VW'(RESET_VALUE);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_REPEAT = 2'd2
  } state_t;

  function automatic logic [VW-1:0] bcd_to_bin(input logic [VW-1:0] b);
    logic [VW-1:0] acc;
    acc = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      acc = acc * VW'(10) + VW'(b[4*i +: 4]);
    end
    return acc;
  endfunction

  function automatic logic [VW-1:0] bin_to_bcd(input logic [VW-1:0] v);
    logic [VW-1:0] r;
    logic [VW-1:0] t;
    r = '0;
    t = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(t % VW'(10));
      t = t / VW'(10);
    end
    return r;
  endfunction

  function automatic logic bcd_valid(input logic [VW-1:0] b);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (b[4*i +: 4] > 4'd9) begin
        ok = 1'b0;
      end else begin
        ok = ok;
      end
    end
    return ok;
  endfunction

  function automatic logic in_range(input logic [VW-1:0] v);
    int iv;
    iv = int'(v);
    return (iv >= MIN_VALUE) && (iv <= MAX_VALUE);
  endfunction

  state_t        state_r, state_n_s;
  logic [CW-1:0] cnt_r, cnt_n_s;
  logic          dir_up_r;
  logic          press_s, abort_s, dir_chg_s;
  logic          step_s, step_up_s;

  logic [VW-1:0] value_r;
  logic          carry_r, borrow_r, load_err_r;
  logic [VW-1:0] cur_bin_s, ld_bin_s, nxt_bin_s;
  logic          ld_ok_s, carry_n_s, borrow_n_s, lerr_n_s;

  assign press_s   = add ^ sub;
  assign abort_s   = clear | load | ~edit | ~press_s;
  assign dir_chg_s = press_s & (add != dir_up_r);

  // Repeat FSM state, hold/rate counter and last pressed direction.
  always_ff @(posedge sysclk) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      cnt_r    <= '0;
      dir_up_r <= 1'b0;
    end else begin
      state_r  <= state_n_s;
      cnt_r    <= cnt_n_s;
      dir_up_r <= press_s ? add : dir_up_r;
    end
  end

  // Repeat FSM next state and counter.
  always_comb begin
    state_n_s = state_r;
    cnt_n_s   = cnt_r;
    if (abort_s) begin
      state_n_s = ST_IDLE;
      cnt_n_s   = '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_n_s = ST_HOLD;
          cnt_n_s   = '0;
        end
        ST_HOLD: begin
          if (dir_chg_s) begin
            cnt_n_s = '0;
          end else if (cnt_r == HOLD_LAST) begin
            state_n_s = ST_REPEAT;
            cnt_n_s   = '0;
          end else begin
            cnt_n_s = cnt_r + CW'(1);
          end
        end
        ST_REPEAT: begin
          if (dir_chg_s) begin
            state_n_s = ST_HOLD;
            cnt_n_s   = '0;
          end else if (cnt_r == REPEAT_LAST) begin
            cnt_n_s = '0;
          end else begin
            cnt_n_s = cnt_r + CW'(1);
          end
        end
        default: begin
          state_n_s = ST_IDLE;
          cnt_n_s   = '0;
        end
      endcase
    end
  end

  // Repeat FSM step request (Mealy on the held button).
  always_comb begin
    step_s    = 1'b0;
    step_up_s = add;
    if (abort_s) begin
      step_s = 1'b0;
    end else begin
      case (state_r)
        ST_IDLE:   step_s = 1'b1;
        ST_HOLD:   step_s = dir_chg_s | (cnt_r == HOLD_LAST);
        ST_REPEAT: step_s = dir_chg_s | (cnt_r == REPEAT_LAST);
        default:   step_s = 1'b0;
      endcase
    end
  end

  assign cur_bin_s = bcd_to_bin(value_r);
  assign ld_bin_s  = bcd_to_bin(load_value);
  assign ld_ok_s   = bcd_valid(load_value) & in_range(ld_bin_s);

  // Next field value and chaining pulses, in clear > load > edit > tick order.
  always_comb begin
    nxt_bin_s  = cur_bin_s;
    carry_n_s  = 1'b0;
    borrow_n_s = 1'b0;
    lerr_n_s   = 1'b0;
    if (clear) begin
      nxt_bin_s = MIN_BIN;
    end else if (load) begin
      if (ld_ok_s) begin
        nxt_bin_s = ld_bin_s;
      end else begin
        lerr_n_s = 1'b1;
      end
    end else if (edit) begin
      if (step_s && step_up_s) begin
        nxt_bin_s = (cur_bin_s == MAX_BIN) ? MIN_BIN : cur_bin_s + VW'(1);
      end else if (step_s) begin
        if (cur_bin_s == MIN_BIN) begin
          nxt_bin_s  = MAX_BIN;
          borrow_n_s = 1'b1;
        end else begin
          nxt_bin_s = cur_bin_s - VW'(1);
        end
      end else begin
        nxt_bin_s = cur_bin_s;
      end
    end else if (tick && !keep) begin
      if (cur_bin_s == MAX_BIN) begin
        nxt_bin_s = MIN_BIN;
        carry_n_s = 1'b1;
      end else begin
        nxt_bin_s = cur_bin_s + VW'(1);
      end
    end else begin
      nxt_bin_s = cur_bin_s;
    end
  end

  // Registered field value and pulse outputs.
  always_ff @(posedge sysclk) begin
    if (rst) begin
      value_r    <= bin_to_bcd(RST_BIN);
      carry_r    <= 1'b0;
      borrow_r   <= 1'b0;
      load_err_r <= 1'b0;
    end else begin
      value_r    <= bin_to_bcd(nxt_bin_s);
      carry_r    <= carry_n_s;
      borrow_r   <= borrow_n_s;
      load_err_r <= lerr_n_s;
    end
  end

  assign value    = value_r;
  assign carry    = carry_r;
  assign borrow   = borrow_r;
  assign load_err = load_err_r;

endmodule
